sram_ctrl: RTL and testbench

Parametrised single-port SRAM controller, successor to the fixed 1024x32 SRAM block. It owns a byte-enabled storage array of configurable width and depth, with configurable access latency and an optional power-up zero-fill sweep. Requests use a valid/ready handshake and one-cycle response pulses, so the accelerator's buffer-fetch logic can stall cleanly. A 2-bit `sram_state` status output keeps the existing status encoding.

---
 rtl/sram_ctrl_pkg.sv | 33 +++
 rtl/sram_bank.sv | 46 ++++
 rtl/sram_ctrl.sv | 170 +++++++++++++++++
 tb/tb_sram_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM controller: external status codes,
// internal FSM states and the latency counter sizing.
package sram_ctrl_pkg;

  localparam int MAX_LATENCY = 7;
  localparam int LAT_W       = 3;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } sram_state_e;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_ACCESS,
    ST_ERR
  } fsm_state_e;

  function automatic sram_state_e status_of(input fsm_state_e s);
    sram_state_e r;
    case (s)
      ST_INIT:   r = BUSY;
      ST_IDLE:   r = FREE;
      ST_ACCESS: r = ACCESS;
      default:   r = ERROR;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sram_bank.sv
// Byte-enabled storage array with a registered read port. The read register
// can also be cleared so it doubles as the controller's response data register.
module sram_bank #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_W-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0]     wr_data_i,
  input  logic [DATA_W/8-1:0]   wr_be_i,
  input  logic                  rd_en_i,
  input  logic                  rd_clr_i,
  input  logic [ADDR_W-1:0]     rd_addr_i,
  output logic [DATA_W-1:0]     rd_data_o
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be_i[i]) mem_q[wr_addr_i][i*8 +: 8] <= wr_data_i[i*8 +: 8];
      end
    end
  end

  // Holds its value unless a read or a clear is requested.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end else if (rd_clr_i) begin
      rd_data_q <= '0;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sram_ctrl.sv
// Single-port SRAM controller: valid/ready request port, one-cycle response
// pulse, configurable access latency and optional zero-fill after reset.
module sram_ctrl #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 1024,
  parameter int ADDR_W    = 10,
  parameter int LATENCY   = 1,
  parameter int INIT_ZERO = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [1:0]          sram_state,
  output logic                init_done
);

  import sram_ctrl_pkg::*;

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
  localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(LATENCY - 1);
  localparam fsm_state_e        RST_STATE = (INIT_ZERO != 0) ? ST_INIT : ST_IDLE;

  fsm_state_e          state_q, state_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [ADDR_W-1:0]   sweep_q, sweep_d;
  logic                init_done_q, init_done_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;

  logic                cap_write_q;
  logic [ADDR_W-1:0]   cap_addr_q;
  logic [DATA_W-1:0]   cap_wdata_q;
  logic [NB-1:0]       cap_be_q;

  logic                accept;
  logic                addr_oob;
  logic                wr_en, rd_en, rd_clr;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [NB-1:0]       wr_be;

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both high; req_valid may be held while req_ready is low.
  assign req_ready = (state_q == ST_IDLE) && init_done_q;
  assign accept    = req_valid && req_ready;
  assign addr_oob  = {1'b0, req_addr} >= DEPTH_X;

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    sweep_d     = sweep_q;
    init_done_d = init_done_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = cap_addr_q;
    wr_data     = cap_wdata_q;
    wr_be       = cap_be_q;
    rd_en       = 1'b0;
    rd_clr      = 1'b0;
    case (state_q)
      ST_INIT: begin
        wr_en   = 1'b1;
        wr_addr = sweep_q;
        wr_data = '0;
        wr_be   = '1;
        if (sweep_q == LAST_ADDR) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
          sweep_d     = '0;
        end else begin
          sweep_d = sweep_q + 1'b1;
        end
      end
      ST_IDLE: begin
        // Without zero-fill the array is usable one edge after reset.
        init_done_d = 1'b1;
        if (accept) begin
          if (addr_oob) begin
            state_d     = ST_ERR;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rd_clr      = 1'b1;
          end else begin
            state_d = ST_ACCESS;
            lat_d   = LAT_LOAD;
          end
        end
      end
      ST_ACCESS: begin
        if (lat_q == '0) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          if (cap_write_q) begin
            wr_en  = 1'b1;
            rd_clr = 1'b1;
          end else begin
            rd_en = 1'b1;
          end
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RST_STATE;
      lat_q       <= '0;
      sweep_q     <= '0;
      init_done_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      sweep_q     <= sweep_d;
      init_done_q <= init_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      cap_write_q <= req_write;
      cap_addr_q  <= req_addr;
      cap_wdata_q <= req_wdata;
      cap_be_q    <= req_be;
    end
  end

  // Reset must block any pending commit, so the array port is gated here.
  sram_bank #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_bank (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (wr_en && !rst),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .wr_be_i   (wr_be),
    .rd_en_i   (rd_en && !rst),
    .rd_clr_i  (rd_clr),
    .rd_addr_i (cap_addr_q),
    .rd_data_o (rsp_rdata)
  );

  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign init_done  = init_done_q;
  assign sram_state = status_of(state_q);

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with DEPTH=12 (non power of two), LATENCY=2
// and zero-fill enabled.
module tb_sram_ctrl;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 12;
  localparam int ADDR_W = 4;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [3:0]        req_be;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [1:0]        sram_state;
  logic              init_done;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];

  sram_ctrl #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .LATENCY   (2),
    .INIT_ZERO (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .sram_state (sram_state),
    .init_done  (init_done)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver: issue one request, return latency (edges after accept), response
  // fields and the status/ready seen in the response cycle.
  task automatic do_req(input logic wr, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wd, input logic [3:0] be,
                        output int lat, output logic [DATA_W-1:0] rd,
                        output logic err, output logic [1:0] st, output logic rdy);
    int n;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_be    = be;
    n = 0;
    while (!req_ready && n < 50) begin
      step();
      n++;
    end
    step();
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      step();
      lat++;
    end
    if (!rsp_valid) lat = -1;
    rd  = rsp_rdata;
    err = rsp_err;
    st  = sram_state;
    rdy = req_ready;
    step();
  endtask

  task automatic test_reset();
    int n;
    logic bad;
    int lat;
    logic [DATA_W-1:0] rd;
    logic err, rdy;
    logic [1:0] st;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; req_be = '0;
    step(); step();
    checks++; if (sram_state !== 2'b01) begin errors++; $display("FAIL reset_state: got %b want 01", sram_state); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp: got v=%b e=%b want 0 0", rsp_valid, rsp_err); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b want 0", init_done); end
    // Hold a read request through INIT; it must not be taken early.
    rst = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd5;
    n = 0; bad = 1'b0;
    while (sram_state == 2'b01 && n < 100) begin
      if (req_ready || rsp_valid || init_done) bad = 1'b1;
      step();
      n++;
    end
    checks++; if (n !== DEPTH) begin errors++; $display("FAIL init_cycles: got %0d want %0d", n, DEPTH); end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL init_quiet: got %b want 0", bad); end
    checks++; if (init_done !== 1'b1 || req_ready !== 1'b1) begin errors++; $display("FAIL init_end: got done=%b rdy=%b want 1 1", init_done, req_ready); end
    checks++; if (sram_state !== 2'b00) begin errors++; $display("FAIL init_free: got %b want 00", sram_state); end
    do_req(1'b0, 4'd5, 32'h0, 4'h0, lat, rd, err, st, rdy);
    checks++; if (lat !== 2 || rd !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL init_read5: got lat=%0d d=%h e=%b want 2 0 0", lat, rd, err); end
  endtask

  task automatic test_write_read();
    int lat;
    logic [DATA_W-1:0] rd;
    logic err, rdy;
    logic [1:0] st;
    do_req(1'b1, 4'd3, 32'hDEADBEEF, 4'hF, lat, rd, err, st, rdy);
    checks++; if (lat !== 2) begin errors++; $display("FAIL wr_latency: got %0d want 2", lat); end
    checks++; if (rd !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL wr_rsp: got d=%h e=%b want 0 0", rd, err); end
    checks++; if (st !== 2'b00 || rdy !== 1'b1) begin errors++; $display("FAIL wr_rsp_cycle: got st=%b rdy=%b want 00 1", st, rdy); end
    do_req(1'b0, 4'd3, 32'h0, 4'h0, lat, rd, err, st, rdy);
    checks++; if (lat !== 2) begin errors++; $display("FAIL rd_latency: got %0d want 2", lat); end
    checks++; if (rd !== 32'hDEADBEEF || err !== 1'b0) begin errors++; $display("FAIL rd_data: got d=%h e=%b want deadbeef 0", rd, err); end
    checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_hold: got v=%b d=%h want 0 deadbeef", rsp_valid, rsp_rdata); end
  endtask

  task automatic test_byte_enable();
    int lat;
    logic [DATA_W-1:0] rd;
    logic err, rdy;
    logic [1:0] st;
    do_req(1'b1, 4'd3, 32'h11223344, 4'b0101, lat, rd, err, st, rdy);
    do_req(1'b0, 4'd3, 32'h0, 4'h0, lat, rd, err, st, rdy);
    checks++; if (rd !== 32'hDE22BE44) begin errors++; $display("FAIL be_0101: got %h want de22be44", rd); end
    do_req(1'b1, 4'd3, 32'hFFFFFFFF, 4'h0, lat, rd, err, st, rdy);
    checks++; if (lat !== 2 || err !== 1'b0) begin errors++; $display("FAIL be_zero_rsp: got lat=%0d e=%b want 2 0", lat, err); end
    do_req(1'b0, 4'd3, 32'h0, 4'h0, lat, rd, err, st, rdy);
    checks++; if (rd !== 32'hDE22BE44) begin errors++; $display("FAIL be_zero_keep: got %h want de22be44", rd); end
  endtask

  task automatic test_out_of_range();
    int lat;
    logic [DATA_W-1:0] rd;
    logic err, rdy;
    logic [1:0] st;
    do_req(1'b1, 4'd1, 32'hA5A5A5A5, 4'hF, lat, rd, err, st, rdy);
    do_req(1'b0, 4'd1, 32'h0, 4'h0, lat, rd, err, st, rdy);
    checks++; if (rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL oob_pre: got %h want a5a5a5a5", rd); end
    do_req(1'b0, 4'd13, 32'h0, 4'h0, lat, rd, err, st, rdy);
    checks++; if (lat !== 0 || err !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL oob_rsp: got lat=%0d e=%b d=%h want 0 1 0", lat, err, rd); end
    checks++; if (st !== 2'b11 || rdy !== 1'b0) begin errors++; $display("FAIL oob_state: got st=%b rdy=%b want 11 0", st, rdy); end
    checks++; if (req_ready !== 1'b1 || sram_state !== 2'b00 || rsp_valid !== 1'b0) begin errors++; $display("FAIL oob_after: got rdy=%b st=%b v=%b want 1 00 0", req_ready, sram_state, rsp_valid); end
    do_req(1'b1, 4'd12, 32'hFFFFFFFF, 4'hF, lat, rd, err, st, rdy);
    checks++; if (lat !== 0 || err !== 1'b1) begin errors++; $display("FAIL oob_wr_depth: got lat=%0d e=%b want 0 1", lat, err); end
    do_req(1'b0, 4'd1, 32'h0, 4'h0, lat, rd, err, st, rdy);
    checks++; if (rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL oob_alias1: got %h want a5a5a5a5", rd); end
    do_req(1'b0, 4'd0, 32'h0, 4'h0, lat, rd, err, st, rdy);
    checks++; if (rd !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL oob_alias0: got d=%h e=%b want 0 0", rd, err); end
    do_req(1'b0, 4'd11, 32'h0, 4'h0, lat, rd, err, st, rdy);
    checks++; if (lat !== 2 || err !== 1'b0) begin errors++; $display("FAIL last_addr: got lat=%0d e=%b want 2 0", lat, err); end
  endtask

  task automatic test_back_to_back();
    int lat, acc, rsp, last_acc;
    logic [DATA_W-1:0] rd, exp;
    logic err, rdy, accept_now, bad_ready, bad_gap, bad_data;
    logic [1:0] st;
    for (int a = 4; a < 8; a++) begin
      do_req(1'b1, ADDR_W'(a), 32'h1000_0000 + DATA_W'(a), 4'hF, lat, rd, err, st, rdy);
    end
    exp_q.delete();
    acc = 0; rsp = 0; last_acc = -1;
    bad_ready = 1'b0; bad_gap = 1'b0; bad_data = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd4;
    for (int c = 0; c < 60 && rsp < 4; c++) begin
      if (sram_state == 2'b10 && req_ready) bad_ready = 1'b1;
      accept_now = req_valid && req_ready;
      step();
      if (rsp_valid) begin
        exp = exp_q.pop_front();
        if (rsp_rdata !== exp) begin
          bad_data = 1'b1;
          $display("FAIL b2b_data: got %h want %h", rsp_rdata, exp);
        end
        rsp++;
      end
      if (accept_now) begin
        if (last_acc >= 0 && c - last_acc != 3) bad_gap = 1'b1;
        last_acc = c;
        exp_q.push_back(32'h1000_0000 + DATA_W'(req_addr));
        acc++;
        if (acc == 4) req_valid = 1'b0;
        else req_addr = ADDR_W'(4 + acc);
      end
    end
    req_valid = 1'b0;
    checks++; if (acc !== 4 || rsp !== 4) begin errors++; $display("FAIL b2b_count: got acc=%0d rsp=%0d want 4 4", acc, rsp); end
    checks++; if (bad_gap !== 1'b0) begin errors++; $display("FAIL b2b_gap: got irregular accept spacing, want 3 cycles"); end
    checks++; if (bad_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_in_access: got 1 want 0"); end
    checks++; if (bad_data !== 1'b0) begin errors++; $display("FAIL b2b_order: got out-of-order data want in order"); end
    step();
  endtask

  task automatic test_reset_mid_access();
    int n, lat;
    logic bad;
    logic [DATA_W-1:0] rd;
    logic err, rdy;
    logic [1:0] st;
    do_req(1'b1, 4'd11, 32'h00000055, 4'hF, lat, rd, err, st, rdy);
    do_req(1'b0, 4'd11, 32'h0, 4'h0, lat, rd, err, st, rdy);
    checks++; if (rd !== 32'h55) begin errors++; $display("FAIL mid_pre: got %h want 55", rd); end
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd7;
    req_wdata = 32'hCAFEF00D; req_be = 4'hF;
    n = 0;
    while (!req_ready && n < 50) begin step(); n++; end
    step();
    req_valid = 1'b0;
    rst = 1'b1;
    checks++; if (sram_state !== 2'b10) begin errors++; $display("FAIL mid_in_access: got %b want 10", sram_state); end
    step();
    checks++; if (rsp_valid !== 1'b0 || sram_state !== 2'b01) begin errors++; $display("FAIL mid_abort: got v=%b st=%b want 0 01", rsp_valid, sram_state); end
    checks++; if (rsp_rdata !== 32'h0 || init_done !== 1'b0) begin errors++; $display("FAIL mid_regs: got d=%h done=%b want 0 0", rsp_rdata, init_done); end
    rst = 1'b0;
    n = 0; bad = 1'b0;
    while (sram_state == 2'b01 && n < 100) begin
      if (rsp_valid) bad = 1'b1;
      step();
      n++;
    end
    checks++; if (n !== DEPTH || bad !== 1'b0) begin errors++; $display("FAIL mid_reinit: got cycles=%0d rsp=%b want %0d 0", n, bad, DEPTH); end
    do_req(1'b0, 4'd7, 32'h0, 4'h0, lat, rd, err, st, rdy);
    checks++; if (rd !== 32'h0 || lat !== 2) begin errors++; $display("FAIL mid_addr7: got d=%h lat=%0d want 0 2", rd, lat); end
    do_req(1'b0, 4'd11, 32'h0, 4'h0, lat, rd, err, st, rdy);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mid_addr11: got %h want 0", rd); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
